// File: rtl/pc_unit.sv
// pc_unit: program counter for the MIPS fetch stage (Address to imem, NextSequential to decode).
// Latency: one cycle; redirect, exception and step results appear on Address the cycle after the edge that samples them.
// Backpressure: Address holds while FetchValid & ~(FetchReady & ~Stall); redirects and exceptions squash the pending request.
//
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   Stall              freezes sequential advance only
//   Redirect, Target   taken branch/jump and its destination
//   Exception          vector to EXCEPTION_VECTOR
//   Halt, Resume       enter HALT from RUN / leave HALT
//   FetchReady         imem accepts Address this cycle
//   Address            registered fetch address
//   FetchValid         registered fetch request valid
//   NextSequential     Address + STEP (combinational, wraps)
//   Misaligned         one-cycle pulse after a misaligned redirect
//   State              00 BOOT, 01 RUN, 10 HALT
module pc_unit #(
  parameter int               WIDTH            = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR     = '0,
  parameter logic [WIDTH-1:0] EXCEPTION_VECTOR = WIDTH'(32'h0000_0180),
  parameter int               STEP             = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] Target,
  input  logic             Exception,
  input  logic             Halt,
  input  logic             Resume,
  input  logic             FetchReady,
  output logic [WIDTH-1:0] Address,
  output logic             FetchValid,
  output logic [WIDTH-1:0] NextSequential,
  output logic             Misaligned,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
  // STEP is a power of two, so Target % STEP reduces to the low address bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_V - 1'b1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             fv_q, fv_d;
  logic             mis_q, mis_d;

  logic             accept;
  logic             target_misaligned;
  logic [WIDTH-1:0] redirect_addr;
  logic [WIDTH-1:0] next_seq;

  assign next_seq          = addr_q + STEP_V;
  assign accept            = fv_q & FetchReady & ~Stall;
  assign target_misaligned = |(Target & ALIGN_MASK);
  // A misaligned target is not fetched; it vectors to the exception handler instead.
  assign redirect_addr     = target_misaligned ? EXCEPTION_VECTOR : Target;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fv_d    = fv_q;
    mis_d   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // First fetch goes out at the reset vector one cycle after reset release.
        state_d = ST_RUN;
        fv_d    = 1'b1;
      end
      ST_RUN: begin
        if (Exception) begin
          addr_d = EXCEPTION_VECTOR;
        end else if (Redirect) begin
          addr_d = redirect_addr;
          mis_d  = target_misaligned;
        end else if (Halt) begin
          state_d = ST_HALT;
          fv_d    = 1'b0;
        end else if (accept) begin
          addr_d = next_seq;
        end
      end
      ST_HALT: begin
        if (Exception) begin
          addr_d  = EXCEPTION_VECTOR;
          state_d = ST_RUN;
          fv_d    = 1'b1;
        end else begin
          // A redirect while halted only retargets; leaving HALT still needs Resume.
          if (Redirect) begin
            addr_d = redirect_addr;
            mis_d  = target_misaligned;
          end
          if (Resume) begin
            state_d = ST_RUN;
            fv_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
        fv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_BOOT;
      addr_q  <= RESET_VECTOR;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  assign Address        = addr_q;
  assign FetchValid     = fv_q;
  assign NextSequential = next_seq;
  assign Misaligned     = mis_q;
  assign State          = state_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // 32-bit, STEP=4 instance
  logic        Reset, Stall, Redirect, Exception, Halt, Resume, FetchReady;
  logic [31:0] Target;
  logic [31:0] Address, NextSequential;
  logic        FetchValid, Misaligned;
  logic [1:0]  State;

  // 16-bit, STEP=2 instance
  logic        r2, fr2;
  logic [15:0] a2, ns2;
  logic        fv2, mis2;
  logic [1:0]  st2;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .Target(Target),
    .Exception(Exception), .Halt(Halt), .Resume(Resume), .FetchReady(FetchReady),
    .Address(Address), .FetchValid(FetchValid), .NextSequential(NextSequential),
    .Misaligned(Misaligned), .State(State)
  );

  pc_unit #(
    .WIDTH(16), .RESET_VECTOR(16'h0000), .EXCEPTION_VECTOR(16'h0180), .STEP(2)
  ) dut16 (
    .Clock(Clock), .Reset(r2), .Stall(1'b0), .Redirect(1'b0), .Target(16'h0000),
    .Exception(1'b0), .Halt(1'b0), .Resume(1'b0), .FetchReady(fr2),
    .Address(a2), .FetchValid(fv2), .NextSequential(ns2),
    .Misaligned(mis2), .State(st2)
  );

  // Reference model for the 32-bit instance: plain integer arithmetic modulo 2^32.
  localparam longint unsigned MOD = 64'h1_0000_0000;
  longint unsigned m_addr;
  bit              m_fv, m_mis;
  int              m_mode;  // 0 boot, 1 run, 2 halt (equal to the State code)

  function automatic void model_step();
    bit mis_next;
    mis_next = 1'b0;
    if (Reset) begin
      m_addr = 0; m_fv = 0; m_mode = 0; m_mis = 0;
      return;
    end
    case (m_mode)
      0: begin m_mode = 1; m_fv = 1; end
      1: begin
        if (Exception) m_addr = 'h180;
        else if (Redirect) begin
          if (Target % 4 == 0) m_addr = Target;
          else begin m_addr = 'h180; mis_next = 1; end
        end
        else if (Halt) begin m_mode = 2; m_fv = 0; end
        else if (m_fv && FetchReady && !Stall) m_addr = (m_addr + 4) % MOD;
      end
      default: begin
        if (Exception) begin m_addr = 'h180; m_mode = 1; m_fv = 1; end
        else begin
          if (Redirect) begin
            if (Target % 4 == 0) m_addr = Target;
            else begin m_addr = 'h180; mis_next = 1; end
          end
          if (Resume) begin m_mode = 1; m_fv = 1; end
        end
      end
    endcase
    m_mis = mis_next;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge Clock);
    model_step();
    #1;
    check("model_addr",    Address,        32'(m_addr));
    check("model_fv",      FetchValid,     32'(m_fv));
    check("model_state",   State,          32'(m_mode));
    check("model_mis",     Misaligned,     32'(m_mis));
    check("model_nextseq", NextSequential, 32'((m_addr + 4) % MOD));
  endtask

  task automatic clear_inputs();
    Stall = 0; Redirect = 0; Exception = 0; Halt = 0; Resume = 0; Target = '0;
  endtask

  initial begin
    clear_inputs();
    FetchReady = 0; Reset = 1; r2 = 1; fr2 = 0;

    // Reset, release, sequential fetch
    cycle(); cycle();
    check("reset_state", State, 32'h0);
    check("reset_fv", FetchValid, 32'h0);
    check("reset_addr", Address, 32'h0);
    FetchReady = 1; Reset = 0;
    cycle();
    check("first_fetch_fv", FetchValid, 32'h1);
    check("first_fetch_addr", Address, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("seq_addr", Address, 32'(i * 4));
    end

    // Hold while not ready, then while stalled
    Redirect = 1; Target = 32'h8; cycle(); Redirect = 0;
    FetchReady = 0;
    for (int i = 0; i < 3; i++) begin cycle(); check("hold_notready", Address, 32'h8); end
    FetchReady = 1; Stall = 1;
    for (int i = 0; i < 2; i++) begin cycle(); check("hold_stall", Address, 32'h8); end
    Stall = 0; cycle();
    check("stall_release", Address, 32'hC);

    // Redirect under stall; exception beats a (misaligned) redirect
    Stall = 1; Redirect = 1; Target = 32'h40; cycle();
    check("redirect_stalled", Address, 32'h40);
    Exception = 1; Target = 32'h42; cycle();
    check("exc_over_redirect", Address, 32'h180);
    check("exc_no_misaligned", Misaligned, 32'h0);
    clear_inputs();

    // Misaligned redirect pulses once
    FetchReady = 0; Redirect = 1; Target = 32'h42; cycle();
    check("misaligned_addr", Address, 32'h180);
    check("misaligned_pulse", Misaligned, 32'h1);
    Redirect = 0; cycle();
    check("misaligned_drop", Misaligned, 32'h0);

    // Halt, redirect while halted, resume
    Redirect = 1; Target = 32'h10; cycle(); Redirect = 0;
    Halt = 1; cycle(); Halt = 0;
    check("halt_state", State, 32'h2);
    check("halt_fv", FetchValid, 32'h0);
    check("halt_addr", Address, 32'h10);
    Redirect = 1; Target = 32'h20; cycle(); Redirect = 0;
    check("halt_redirect_addr", Address, 32'h20);
    check("halt_redirect_state", State, 32'h2);
    Resume = 1; FetchReady = 1; cycle(); Resume = 0;
    check("resume_state", State, 32'h1);
    check("resume_fv", FetchValid, 32'h1);
    cycle();
    check("resume_accept", Address, 32'h24);

    // Wrap at the top of the address space; reset out of HALT
    Redirect = 1; Target = 32'hFFFF_FFFC; cycle(); Redirect = 0;
    check("nextseq_wrap", NextSequential, 32'h0);
    cycle();
    check("addr_wrap", Address, 32'h0);
    Halt = 1; cycle(); Halt = 0;
    Reset = 1; Resume = 1; cycle(); Reset = 0; Resume = 0;
    check("reset_from_halt_addr", Address, 32'h0);
    check("reset_from_halt_state", State, 32'h0);

    // 16-bit, STEP=2 instance
    fr2 = 1; cycle();
    check("w16_reset_fv", 32'(fv2), 32'h0);
    check("w16_reset_state", 32'(st2), 32'h0);
    r2 = 0; cycle();
    check("w16_first_fv", 32'(fv2), 32'h1);
    check("w16_first_addr", 32'(a2), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("w16_seq_addr", 32'(a2), 32'(i * 2));
      check("w16_nextseq", 32'(ns2), 32'(i * 2 + 2));
    end
    check("w16_mis", 32'(mis2), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      Reset      = ($urandom_range(0, 59) == 0);
      Exception  = ($urandom_range(0, 19) == 0);
      Redirect   = ($urandom_range(0, 7) == 0);
      Halt       = ($urandom_range(0, 15) == 0);
      Resume     = ($urandom_range(0, 3) == 0);
      Stall      = ($urandom_range(0, 3) == 0);
      FetchReady = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       Target = $urandom;
        1:       Target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: Target = $urandom & 32'hFFFF_FFFC;
      endcase
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
